// File: rtl/led_pattern_sequencer_pkg.sv
// led_seq_pkg: mode encoding and pattern helpers shared by the LED sequencer.
// Optional build macro used elsewhere in this block: LED_PWM_EN.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'd0,
        MODE_BIN  = 2'd1,
        MODE_SCAN = 2'd2,
        MODE_FILL = 2'd3
    } mode_t;

    localparam int GRAY_MAX_W = 32;

    // Gray code of the low 'bits' bits of b; callers zero-extend into the
    // wide argument and size-cast the result back to their own width.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                       input int bits);
        logic [GRAY_MAX_W-1:0] keep;
        keep = (GRAY_MAX_W'(1) << bits) - GRAY_MAX_W'(1);
        return (b ^ (b >> 1)) & keep;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// led_seq_if: pin-side bundle of the LED sequencer.
// LED_PWM_EN adds the 4-bit brightness input.
interface led_seq_if #(parameter int BITS = 8) ();
    logic            btn;
    logic            hold;
    logic [BITS-1:0] led;
    logic [1:0]      mode;
    logic            tick;
`ifdef LED_PWM_EN
    logic [3:0]      bright;

    modport master (output btn, hold, bright, input led, mode, tick);
    modport slave  (input btn, hold, bright, output led, mode, tick);
`else
    modport master (output btn, hold, input led, mode, tick);
    modport slave  (input btn, hold, output led, mode, tick);
`endif
endinterface

// File: rtl/led_pattern_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and press pulse.
// press is a one-cycle pulse in the cycle the debounced level turns 1.
module btn_debounce #(
    parameter int DEBOUNCE_LOG2 = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic                     sync1;
    logic                     synced;
    logic                     stable;
    logic [DEBOUNCE_LOG2-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            synced <= 1'b0;
        end else begin
            sync1  <= btn;
            synced <= sync1;
        end
    end

    // Accept a new level only after it has differed for 2^DEBOUNCE_LOG2 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (synced == stable) begin
                cnt <= '0;
            end else if (cnt == '1) begin
                stable <= synced;
                cnt    <= '0;
                press  <= synced;
            end else begin
                cnt <= cnt + DEBOUNCE_LOG2'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: four-mode LED pattern engine (gray, binary, scan, fill)
// paced by a prescaler tick and advanced by a debounced button.
// Build macro LED_PWM_EN adds bus.bright and a 16-step PWM dimmer on led.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int BITS          = 8,
    parameter int LOG2DELAY     = 22,
    parameter int DEBOUNCE_LOG2 = 16
) (
    input logic      clk,
    input logic      rst,
    led_seq_if.slave bus
);

    localparam int PW = $clog2(BITS);
    localparam int FW = $clog2(BITS + 1);
    localparam logic [PW-1:0]   POS_MAX = PW'(BITS - 1);
    localparam logic [FW-1:0]   F_MAX   = FW'(BITS);
    localparam logic [BITS-1:0] ONE     = BITS'(1);

    mode_t                mode_q, mode_n;
    logic [BITS-1:0]      cnt_q, cnt_n;
    logic [PW-1:0]        pos_q, pos_n;
    logic                 dir_up_q, dir_up_n;
    logic [FW-1:0]        f_q, f_n;
    logic [LOG2DELAY-1:0] pre_q, pre_n;
    logic [BITS-1:0]      pat;
    logic [BITS-1:0]      led_q;
    logic                 press;
    logic                 wrap;
    logic                 lit;

    btn_debounce #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.btn),
        .press (press)
    );

    // A press in the wrap cycle swallows the tick; the mode change wins.
    assign wrap     = (pre_q == '1) && !bus.hold;
    assign bus.tick = wrap && !press;
    assign bus.mode = mode_q;
    assign bus.led  = led_q;

    // State register for mode and per-mode step state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MODE_GRAY;
            cnt_q    <= '0;
            pos_q    <= '0;
            dir_up_q <= 1'b1;
            f_q      <= '0;
            pre_q    <= '0;
        end else begin
            mode_q   <= mode_n;
            cnt_q    <= cnt_n;
            pos_q    <= pos_n;
            dir_up_q <= dir_up_n;
            f_q      <= f_n;
            pre_q    <= pre_n;
        end
    end

    // Next state: press restarts the new mode at step 0, otherwise a tick
    // steps only the active mode's state.
    always_comb begin
        mode_n   = mode_q;
        cnt_n    = cnt_q;
        pos_n    = pos_q;
        dir_up_n = dir_up_q;
        f_n      = f_q;
        pre_n    = bus.hold ? pre_q : pre_q + LOG2DELAY'(1);
        if (press) begin
            case (mode_q)
                MODE_GRAY: mode_n = MODE_BIN;
                MODE_BIN:  mode_n = MODE_SCAN;
                MODE_SCAN: mode_n = MODE_FILL;
                default:   mode_n = MODE_GRAY;
            endcase
            cnt_n    = '0;
            pos_n    = '0;
            dir_up_n = 1'b1;
            f_n      = '0;
            pre_n    = '0;
        end else if (wrap) begin
            case (mode_q)
                MODE_GRAY, MODE_BIN: cnt_n = cnt_q + BITS'(1);
                MODE_SCAN: begin
                    if (dir_up_q) begin
                        if (pos_q == POS_MAX) begin
                            dir_up_n = 1'b0;
                            pos_n    = POS_MAX - PW'(1);
                        end else begin
                            pos_n = pos_q + PW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            dir_up_n = 1'b1;
                            pos_n    = PW'(1);
                        end else begin
                            pos_n = pos_q - PW'(1);
                        end
                    end
                end
                default: f_n = (f_q == F_MAX) ? '0 : f_q + FW'(1);
            endcase
        end
    end

    // Pattern of the state being loaded, so led shows it right after the edge.
    always_comb begin
        pat = '0;
        case (mode_n)
            MODE_GRAY: pat = BITS'(bin2gray(GRAY_MAX_W'(cnt_n), BITS));
            MODE_BIN:  pat = cnt_n;
            MODE_SCAN: pat[pos_n] = 1'b1;
            default:   pat = (ONE << f_n) - ONE;
        endcase
    end

`ifdef LED_PWM_EN
    logic [3:0] pwm_q;

    // Free-running 16-step PWM phase for dimming.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_q <= 4'd0;
        else     pwm_q <= pwm_q + 4'd1;
    end

    assign lit = (pwm_q < bus.bright);
`else
    assign lit = 1'b1;
`endif

    // Registered LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) led_q <= '0;
        else     led_q <= pat & {BITS{lit}};
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: table vectors, directed corner sequences and a
// randomized run against a step-count reference model.
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

    localparam int BITS          = 8;
    localparam int LOG2DELAY     = 2;
    localparam int DEBOUNCE_LOG2 = 2;
    localparam int SCAN_PERIOD   = 2 * (BITS - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    led_seq_if #(.BITS(BITS)) bus ();

    led_pattern_sequencer #(
        .BITS(BITS), .LOG2DELAY(LOG2DELAY), .DEBOUNCE_LOG2(DEBOUNCE_LOG2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Brightness gate expected on led for the current cycle.
    logic mask_m;
`ifdef LED_PWM_EN
    logic [3:0] pwm_m;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_m  <= 4'd0;
            mask_m <= 1'b0;
        end else begin
            mask_m <= (pwm_m < bus.bright);
            pwm_m  <= pwm_m + 4'd1;
        end
    end
`else
    assign mask_m = 1'b1;
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        int         md;
        int         ticks;
        logic [7:0] led;
    } vec_t;

    vec_t tbl[$];

    // Expected pattern k ticks after entering mode md.
    function automatic logic [BITS-1:0] ref_pattern(input int md, input int k);
        int s;
        logic [BITS-1:0] v;
        case (md)
            0: begin v = BITS'(k % (1 << BITS)); v = v ^ (v >> 1); end
            1: v = BITS'(k % (1 << BITS));
            2: begin
                s = k % SCAN_PERIOD;
                v = BITS'(1 << ((s < BITS) ? s : SCAN_PERIOD - s));
            end
            default: begin s = k % (BITS + 1); v = BITS'((1 << s) - 1); end
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_led(input string name, input logic [BITS-1:0] pat);
        check(name, 32'(bus.led), 32'(pat & {BITS{mask_m}}));
    endtask

    task automatic add_vec(input int md, input int t, input logic [7:0] l);
        vec_t v;
        v.md = md; v.ticks = t; v.led = l;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        bus.btn  = 1'b0;
        bus.hold = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Let any release settle, then hold btn until the mode moves on.
    task automatic press_once();
        int budget;
        logic [1:0] m0, m1;
        bus.btn = 1'b0;
        repeat (12) @(negedge clk);
        m0 = bus.mode;
        m1 = m0 + 2'd1;
        bus.btn = 1'b1;
        budget = 30;
        while (bus.mode == m0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        bus.btn = 1'b0;
        check("press_advance", 32'(bus.mode), 32'(m1));
    endtask

    // Returns at the negedge after the n-th tick, when led shows that step.
    task automatic run_ticks(input int n);
        int seen, budget;
        seen = 0;
        budget = n * 4 + 40;
        while (seen < n && budget > 0) begin
            if (bus.tick) seen++;
            @(negedge clk);
            budget--;
        end
        check("tick_budget", seen, n);
    endtask

    int         nt, first_t, hits;
    int         m_mode, m_k, m_ph, seg_left;
    logic       seg_high, press_now, exp_tick;
    logic [7:0] hsh;

    initial begin
`ifdef LED_PWM_EN
        bus.bright = 4'd15;
`endif
        // Reset values and free-running tick spacing in GRAY.
        do_reset();
        check("rst_led", 32'(bus.led), 32'h0);
        check("rst_mode", 32'(bus.mode), 32'h0);
        check("rst_tick", 32'(bus.tick), 32'h0);
        nt = 0; first_t = -1;
        for (int c = 0; c < 40; c++) begin
            if (bus.tick) begin
                if (first_t < 0) first_t = c;
                nt++;
            end
            @(negedge clk);
        end
        check("tick_count_40", nt, 10);
        check("tick_first", first_t, 3);
        check("mode_idle", 32'(bus.mode), 32'h0);

        // Table vectors: mode reached by presses, n ticks, expected led.
        add_vec(0, 0, 8'h00);   add_vec(0, 1, 8'h01);   add_vec(0, 2, 8'h03);
        add_vec(0, 3, 8'h02);   add_vec(0, 4, 8'h06);   add_vec(0, 8, 8'h0C);
        add_vec(0, 255, 8'h80); add_vec(0, 256, 8'h00);
        add_vec(1, 0, 8'h00);   add_vec(1, 3, 8'h03);
        add_vec(1, 255, 8'hFF); add_vec(1, 256, 8'h00);
        add_vec(2, 0, 8'h01);   add_vec(2, 7, 8'h80);   add_vec(2, 8, 8'h40);
        add_vec(2, 14, 8'h01);  add_vec(2, 15, 8'h02);  add_vec(2, 16, 8'h04);
        add_vec(3, 0, 8'h00);   add_vec(3, 3, 8'h07);
        add_vec(3, 8, 8'hFF);   add_vec(3, 9, 8'h00);
        foreach (tbl[i]) begin
            do_reset();
            for (int p = 0; p < tbl[i].md; p++) press_once();
            run_ticks(tbl[i].ticks);
            check("vec_mode", 32'(bus.mode), 32'(tbl[i].md));
            check_led("vec_led", tbl[i].led);
        end

        // Glitches shorter than the debounce window, then one long press.
        do_reset();
        bus.btn = 1'b1; repeat (2) @(negedge clk);
        bus.btn = 1'b0; repeat (20) @(negedge clk);
        check("glitch2_mode", 32'(bus.mode), 32'h0);
        bus.btn = 1'b1; repeat (3) @(negedge clk);
        bus.btn = 1'b0; repeat (20) @(negedge clk);
        check("glitch3_mode", 32'(bus.mode), 32'h0);
        bus.btn = 1'b1; repeat (10) @(negedge clk);
        bus.btn = 1'b0; repeat (30) @(negedge clk);
        check("long_press_once", 32'(bus.mode), 32'h1);

        // Press landing in a tick cycle: tick suppressed, prescaler restarts.
        do_reset();
        hits = 40;
        while (!bus.tick && hits > 0) begin @(negedge clk); hits--; end
        check("sync_tick_seen", 32'(bus.tick), 32'h1);
        repeat (2) @(negedge clk);
        bus.btn = 1'b1;
        repeat (6) @(negedge clk);
        check("coinc_tick", 32'(bus.tick), 32'h0);
        check("coinc_mode_before", 32'(bus.mode), 32'h0);
        @(negedge clk);
        bus.btn = 1'b0;
        check("coinc_mode_after", 32'(bus.mode), 32'h1);
        check_led("coinc_led", 8'h00);
        repeat (3) @(negedge clk);
        check("tick_after_press", 32'(bus.tick), 32'h1);

        // Hold freezes stepping but not the mode button.
        do_reset();
        run_ticks(5);
        bus.hold = 1'b1;
        nt = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.tick) nt++;
            @(negedge clk);
        end
        check("hold_ticks", nt, 0);
        check_led("hold_led", 8'h07);
        press_once();
        check("hold_press_mode", 32'(bus.mode), 32'h1);
        bus.hold = 1'b0;

        // Asynchronous reset in the middle of SCAN.
        do_reset();
        press_once();
        press_once();
        run_ticks(5);
        check_led("scan_pos5", 8'h20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", 32'(bus.led), 32'h0);
        check("async_rst_mode", 32'(bus.mode), 32'h0);
        check("async_rst_tick", 32'(bus.tick), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_release_tick", 32'(bus.tick), 32'h0);
        repeat (20) @(negedge clk);
        check("rst_release_mode", 32'(bus.mode), 32'h0);

`ifdef LED_PWM_EN
        // Dimming duty with FILL at full scale.
        do_reset();
        bus.bright = 4'd4;
        for (int p = 0; p < 3; p++) press_once();
        run_ticks(8);
        bus.hold = 1'b1;
        hits = 0;
        for (int c = 0; c < 32; c++) begin
            if (bus.led == 8'hFF) hits++;
            @(negedge clk);
        end
        check("pwm_duty", hits, 8);
        bus.hold = 1'b0;
        bus.bright = 4'd15;
`endif

        // Randomized run: model counts ticks per mode and prescaler phase.
        do_reset();
        m_mode = 0; m_k = 0; m_ph = 0; hsh = '0;
        seg_high = 1'b0; seg_left = 20;
        for (int c = 0; c < 4000; c++) begin
            check_led("rnd_led", ref_pattern(m_mode, m_k));
            check("rnd_mode", 32'(bus.mode), 32'(m_mode));
            if (seg_left == 0) begin
                if (seg_high) begin
                    seg_high = 1'b0;
                    seg_left = $urandom_range(10, 120);
                end else begin
                    seg_high = 1'b1;
                    seg_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 10);
                end
            end
            seg_left--;
            bus.btn  = seg_high;
            bus.hold = ($urandom_range(0, 7) == 0);
            // A rise held for 4 samples is accepted as a press 6 edges on.
            hsh = {hsh[6:0], seg_high};
            press_now = (hsh[6:3] == 4'hF) && !hsh[7];
            #1;
            exp_tick = (m_ph == 3) && !bus.hold && !press_now;
            check("rnd_tick", 32'(bus.tick), 32'(exp_tick));
            if (press_now) begin
                m_mode = (m_mode + 1) % 4;
                m_k = 0;
                m_ph = 0;
            end else begin
                if (!bus.hold) m_ph = (m_ph + 1) % 4;
                if (exp_tick) m_k++;
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
